// File: rtl/ex_ctrl_pkg.sv
// Shared types and encodings for the execute-stage pipeline controller.
package ex_ctrl_pkg;

  localparam int unsigned REG_W     = 5;
  localparam int unsigned ALUOP_W   = 2;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned MUL_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_BR_FLUSH = 2'd2
  } state_e;

  localparam logic [ALUOP_W-1:0] ALUOP_LW    = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SW    = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_ADDI  = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b000000;
  localparam logic [FUNCT_W-1:0] FUNCT_MUL = 6'b000001;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b000010;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination feeds a source operand of the instruction in ID.
module load_use_detect
  import ex_ctrl_pkg::*;
(
  input  logic             i_ex_valid,
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_rd_addr,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs_addr,
  input  logic [REG_W-1:0] i_id_rt_addr,
  output logic             o_load_use
);

  logic w_rd_nonzero;
  logic w_src_match;

  // Register 0 is hardwired, so a load into it never creates a dependency.
  assign w_rd_nonzero = (i_ex_rd_addr != '0);
  assign w_src_match  = (i_ex_rd_addr == i_id_rs_addr) | (i_ex_rd_addr == i_id_rt_addr);
  assign o_load_use   = i_ex_valid & i_ex_mem_read & i_id_valid & w_rd_nonzero & w_src_match;

endmodule

// File: rtl/ex_stage_ctrl.sv
// Execute-stage sequencer: load-use stalls, multi-cycle multiply hold and
// taken-branch squash, plus a saturating count of stalled cycles.
module ex_stage_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [REG_W-1:0]   id_rs_addr,
  input  logic [REG_W-1:0]   id_rt_addr,
  input  logic               ex_valid,
  input  logic               ex_mem_read,
  input  logic [REG_W-1:0]   ex_rd_addr,
  input  logic [ALUOP_W-1:0] ex_aluop,
  input  logic [FUNCT_W-1:0] ex_funct,
  input  logic               ex_branch,
  input  logic               ex_zero,
  output logic               stall_flag,
  output logic               flush_if_id,
  output logic               flush_id_ex,
  output logic               mul_busy,
  output logic [CNT_W-1:0]   stall_count
);

  localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_CNT_W'(MUL_CYCLES - 2);

  state_e                 r_state;
  state_e                 w_next_state;
  logic [MUL_CNT_W-1:0]   r_mul_cnt;
  logic [CNT_W-1:0]       r_stall_count;
  logic                   w_load_use;
  logic                   w_ex_mul;
  logic                   w_br_taken;
  logic                   w_stall;
  logic                   w_flush_if_id;
  logic                   w_flush_id_ex;
  logic                   w_mul_busy;

  load_use_detect u_load_use_detect (
    .i_ex_valid    (ex_valid),
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rd_addr  (ex_rd_addr),
    .i_id_valid    (id_valid),
    .i_id_rs_addr  (id_rs_addr),
    .i_id_rt_addr  (id_rt_addr),
    .o_load_use    (w_load_use)
  );

  assign w_ex_mul   = ex_valid & (ex_aluop == ALUOP_RTYPE) & (ex_funct == FUNCT_MUL);
  assign w_br_taken = ex_valid & ex_branch & ex_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_br_taken) begin
          w_next_state = ST_BR_FLUSH;
        end else if (w_ex_mul) begin
          w_next_state = ST_MUL_WAIT;
        end
      end
      ST_MUL_WAIT: begin
        if (r_mul_cnt == '0) begin
          w_next_state = ST_RUN;
        end
      end
      ST_BR_FLUSH: w_next_state = ST_RUN;
      default:     w_next_state = ST_RUN;
    endcase
  end

  // Mealy outputs; hazard checks only matter in RUN.
  always_comb begin
    w_stall       = 1'b0;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    w_mul_busy    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_br_taken) begin
          w_flush_if_id = 1'b1;
          w_flush_id_ex = 1'b1;
        end else if (w_ex_mul) begin
          w_stall    = 1'b1;
          w_mul_busy = 1'b1;
        end else if (w_load_use) begin
          w_stall = 1'b1;
        end
      end
      ST_MUL_WAIT: begin
        w_mul_busy = 1'b1;
        w_stall    = (r_mul_cnt != '0);
      end
      ST_BR_FLUSH: w_flush_if_id = 1'b1;
      default: ;
    endcase
  end

  assign stall_flag  = reset & w_stall;
  assign flush_if_id = reset & w_flush_if_id;
  assign flush_id_ex = reset & w_flush_id_ex;
  assign mul_busy    = reset & w_mul_busy;
  assign stall_count = r_stall_count;

  // Remaining multiply hold cycles; the last MUL_WAIT cycle (count 0) is unstalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mul_cnt <= '0;
    end else if ((r_state == ST_RUN) && (w_next_state == ST_MUL_WAIT)) begin
      r_mul_cnt <= MUL_LOAD;
    end else if ((r_state == ST_MUL_WAIT) && (r_mul_cnt != '0)) begin
      r_mul_cnt <= r_mul_cnt - MUL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (stall_flag && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Directed bench for ex_stage_ctrl: three parameterisations share one stimulus
// stream; expected outputs are queued per step and checked at the falling edge.
module tb_ex_stage_ctrl;
  import ex_ctrl_pkg::*;

  logic               clk;
  logic               reset;
  logic               id_valid;
  logic [REG_W-1:0]   id_rs_addr;
  logic [REG_W-1:0]   id_rt_addr;
  logic               ex_valid;
  logic               ex_mem_read;
  logic [REG_W-1:0]   ex_rd_addr;
  logic [ALUOP_W-1:0] ex_aluop;
  logic [FUNCT_W-1:0] ex_funct;
  logic               ex_branch;
  logic               ex_zero;

  logic        a_stall, a_fii, a_fie, a_busy;
  logic [15:0] a_cnt;
  logic        b_stall, b_fii, b_fie, b_busy;
  logic [15:0] b_cnt;
  logic        c_stall, c_fii, c_fie, c_busy;
  logic [3:0]  c_cnt;

  ex_stage_ctrl #(.MUL_CYCLES(4), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr), .ex_aluop(ex_aluop), .ex_funct(ex_funct),
    .ex_branch(ex_branch), .ex_zero(ex_zero), .stall_flag(a_stall),
    .flush_if_id(a_fii), .flush_id_ex(a_fie), .mul_busy(a_busy), .stall_count(a_cnt)
  );

  ex_stage_ctrl #(.MUL_CYCLES(2), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr), .ex_aluop(ex_aluop), .ex_funct(ex_funct),
    .ex_branch(ex_branch), .ex_zero(ex_zero), .stall_flag(b_stall),
    .flush_if_id(b_fii), .flush_id_ex(b_fie), .mul_busy(b_busy), .stall_count(b_cnt)
  );

  ex_stage_ctrl #(.MUL_CYCLES(4), .CNT_W(4)) u_dut_c (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr), .ex_aluop(ex_aluop), .ex_funct(ex_funct),
    .ex_branch(ex_branch), .ex_zero(ex_zero), .stall_flag(c_stall),
    .flush_if_id(c_fii), .flush_id_ex(c_fie), .mul_busy(c_busy), .stall_count(c_cnt)
  );

  // Observed vector per instance: {stall, flush_if_id, flush_id_ex, mul_busy, count}
  logic [19:0] obs [3];
  assign obs[0] = {a_stall, a_fii, a_fie, a_busy, a_cnt};
  assign obs[1] = {b_stall, b_fii, b_fie, b_busy, b_cnt};
  assign obs[2] = {c_stall, c_fii, c_fie, c_busy, 16'(c_cnt)};

  typedef struct {
    int          inst;
    string       tag;
    logic [19:0] val;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid    = 1'b0;
    id_rs_addr  = '0;
    id_rt_addr  = '0;
    ex_valid    = 1'b0;
    ex_mem_read = 1'b0;
    ex_rd_addr  = '0;
    ex_aluop    = ALUOP_ADDI;
    ex_funct    = FUNCT_SUB;
    ex_branch   = 1'b0;
    ex_zero     = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    ex_valid    = 1'b1;
    ex_mem_read = 1'b1;
    ex_rd_addr  = rd;
    ex_aluop    = ALUOP_LW;
    ex_funct    = FUNCT_ADD;
    id_valid    = 1'b1;
    id_rs_addr  = rs;
    id_rt_addr  = rt;
  endtask

  task automatic set_mul();
    set_idle();
    ex_valid = 1'b1;
    ex_aluop = ALUOP_RTYPE;
    ex_funct = FUNCT_MUL;
  endtask

  task automatic push(input int inst, input string tag, input logic s, input logic f1,
                      input logic f2, input logic b, input int c);
    exp_t e;
    e.inst = inst;
    e.tag  = tag;
    e.val  = {s, f1, f2, b, 16'(c)};
    q.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      assert (obs[e.inst] === e.val)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h (stall,fii,fie,busy,count)", e.tag, obs[e.inst], e.val);
      end
    end
  endtask

  initial begin
    int stalls;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    set_idle();

    // Reset: every output zero, even with hazards presented
    for (int k = 0; k < 3; k++) push(k, "reset_idle", 0, 0, 0, 0, 0);
    chk();
    cyc(); set_mul(); ex_branch = 1'b1; ex_zero = 1'b1;
    for (int k = 0; k < 3; k++) push(k, "reset_forced", 0, 0, 0, 0, 0);
    chk();
    cyc(); set_idle(); reset = 1'b1;
    push(0, "post_reset", 0, 0, 0, 0, 0); chk();

    // Load-use
    cyc(); set_load(5'd5, 5'd5, 5'd0); push(0, "lu_rs_stall", 1, 0, 0, 0, 0); chk();
    cyc(); ex_valid = 1'b0;            push(0, "lu_one_cycle", 0, 0, 0, 0, 1); chk();
    cyc(); set_load(5'd0, 5'd0, 5'd0); push(0, "lu_rd_zero", 0, 0, 0, 0, 1); chk();
    cyc(); set_load(5'd7, 5'd3, 5'd7); push(0, "lu_rt_stall", 1, 0, 0, 0, 1); chk();
    cyc(); ex_valid = 1'b0;            push(0, "lu_ex_invalid", 0, 0, 0, 0, 2); chk();
    cyc(); set_load(5'd7, 5'd7, 5'd0); id_valid = 1'b0;
    push(0, "lu_id_invalid", 0, 0, 0, 0, 2); chk();

    // Multiply, MUL_CYCLES=4
    cyc(); set_idle(); ex_valid = 1'b1; ex_aluop = ALUOP_RTYPE; ex_funct = FUNCT_ADD;
    push(0, "rtype_add", 0, 0, 0, 0, 2); chk();
    cyc(); set_mul();                           push(0, "mul_c0", 1, 0, 0, 1, 2); chk();
    cyc();                                      push(0, "mul_c1", 1, 0, 0, 1, 3); chk();
    cyc(); ex_branch = 1'b1; ex_zero = 1'b1;    push(0, "mul_c2_br_ignored", 1, 0, 0, 1, 4); chk();
    cyc(); set_mul();                           push(0, "mul_c3_unstalled", 0, 0, 0, 1, 5); chk();
    cyc(); set_idle();                          push(0, "mul_done", 0, 0, 0, 0, 5); chk();

    // Taken branch with concurrent load-use
    cyc(); set_load(5'd5, 5'd5, 5'd0); ex_aluop = ALUOP_BEQ; ex_branch = 1'b1; ex_zero = 1'b1;
    push(0, "br_resolve", 0, 1, 1, 0, 5); chk();
    cyc(); set_idle(); ex_valid = 1'b1; ex_branch = 1'b1; ex_zero = 1'b1;
    push(0, "br_flush", 0, 1, 0, 0, 5); chk();
    cyc(); set_idle();                          push(0, "br_back_run", 0, 0, 0, 0, 5); chk();
    cyc(); ex_valid = 1'b1; ex_aluop = ALUOP_BEQ; ex_branch = 1'b1; ex_zero = 1'b0;
    push(0, "br_not_taken", 0, 0, 0, 0, 5); chk();
    cyc(); ex_valid = 1'b0; ex_zero = 1'b1;     push(0, "br_invalid", 0, 0, 0, 0, 5); chk();

    // Reset in the second MUL_WAIT cycle
    cyc(); set_mul();                           push(0, "rst_mul_c0", 1, 0, 0, 1, 5); chk();
    cyc();                                      push(0, "rst_mul_c1", 1, 0, 0, 1, 6); chk();
    cyc(); reset = 1'b0;                        push(0, "rst_mid_mul", 0, 0, 0, 0, 0); chk();
    cyc(); set_idle(); reset = 1'b1;            push(0, "rst_release", 0, 0, 0, 0, 0); chk();
    cyc(); set_load(5'd9, 5'd0, 5'd9);          push(0, "rst_run_lu", 1, 0, 0, 0, 0); chk();
    cyc(); set_idle();                          push(0, "rst_run_idle", 0, 0, 0, 0, 1); chk();

    // Multiply, MUL_CYCLES=2
    cyc(); reset = 1'b0;                        push(1, "m2_reset", 0, 0, 0, 0, 0); chk();
    cyc(); reset = 1'b1;                        push(1, "m2_release", 0, 0, 0, 0, 0); chk();
    cyc(); set_mul();                           push(1, "m2_c0", 1, 0, 0, 1, 0); chk();
    cyc();                                      push(1, "m2_c1", 0, 0, 0, 1, 1); chk();
    cyc(); set_idle();                          push(1, "m2_done", 0, 0, 0, 0, 1); chk();

    // Saturation, CNT_W=4, back-to-back multiplies
    cyc(); reset = 1'b0;                        push(2, "sat_reset", 0, 0, 0, 0, 0); chk();
    cyc(); reset = 1'b1;                        push(2, "sat_release", 0, 0, 0, 0, 0); chk();
    stalls = 0;
    for (int i = 0; i < 24; i++) begin
      logic s;
      cyc();
      if (i == 0) set_mul();
      s = ((i % 4) != 3);
      push(2, "sat_chain", s, 0, 0, 1, (stalls > 15) ? 15 : stalls);
      chk();
      if (s) stalls++;
    end
    cyc(); set_idle();                          push(2, "sat_hold", 0, 0, 0, 0, 15); chk();
    cyc();                                      push(2, "sat_stuck", 0, 0, 0, 0, 15); chk();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage_ctrl.md
# ex_stage_ctrl

Pipeline controller that sequences the execute stage. It detects load-use hazards between the EX and ID stages, holds EX for a multi-cycle multiply, and squashes younger instructions on a taken branch. It drives the shared `stall_flag` consumed by the IF, ID and EX stages, plus the two pipeline-register flush strobes. It sits beside the EX stage and takes its inputs from the ID/EX and EX pipeline registers.

## Interface
- `MUL_CYCLES`, default 4: total cycles a multiply occupies EX; legal range 2..16.
- `CNT_W`, default 16: width of the saturating stall-cycle counter.

Ports:
- `clk` input, 1: single clock; all state updates on the rising edge.
- `reset` input, 1: asynchronous, active-low reset.
- `id_valid` input, 1: ID holds a real instruction.
- `id_rs_addr`, `id_rt_addr` input, 5 each: source register numbers of the instruction in ID.
- `ex_valid` input, 1: EX holds a real instruction.
- `ex_mem_read` input, 1: the EX instruction is a load.
- `ex_rd_addr` input, 5: destination register of the EX instruction.
- `ex_aluop` input, 2: ALUOp of the EX instruction.
- `ex_funct` input, 6: funct field of the EX instruction.
- `ex_branch` input, 1: the EX instruction is a branch.
- `ex_zero` input, 1: ALU equality result for the EX instruction.
- `stall_flag` output, 1: freeze PC, IF/ID and ID/EX, and hold EX.
- `flush_if_id` output, 1: squash the IF/ID register at the next edge.
- `flush_id_ex` output, 1: squash the ID/EX register at the next edge.
- `mul_busy` output, 1: a multiply is occupying EX.
- `stall_count` output, CNT_W: number of cycles with `stall_flag`=1, saturating.

## Operation
- States: RUN, MUL_WAIT, BR_FLUSH. A 4-bit down-counter `mul_cnt` is used in MUL_WAIT.
- `ex_mul` = `ex_valid` & (`ex_aluop`==2'b10) & (`ex_funct`==6'b000001).
- `br_taken` = `ex_valid` & `ex_branch` & `ex_zero`.
- `load_use` = `ex_valid` & `ex_mem_read` & `id_valid` & (`ex_rd_addr`!=0) & (`ex_rd_addr`==`id_rs_addr` | `ex_rd_addr`==`id_rt_addr`).
- RUN outputs are Mealy, in priority order:
  - `br_taken`: `flush_if_id`=`flush_id_ex`=1, `stall_flag`=0; next state BR_FLUSH.
  - else `ex_mul`: `stall_flag`=1, `mul_busy`=1; next state MUL_WAIT with `mul_cnt`=MUL_CYCLES-2.
  - else `load_use`: `stall_flag`=1 for this cycle; stay in RUN. The stalled load advances, and the next cycle re-evaluates the check.
  - else all outputs 0.
- MUL_WAIT:
  - `mul_busy`=1 and `stall_flag`=(`mul_cnt`!=0).
  - `mul_cnt` decrements each edge. When `mul_cnt`==0, next state is RUN.
  - The branch and load-use checks are ignored in this state.
- BR_FLUSH: `flush_if_id`=1 only (this drops the wrong-path fetch); next state RUN unconditionally.
- `stall_count` increments on every edge where `stall_flag`=1 and holds at all-ones.

## Timing
- Reset value of every output is 0, forced combinationally while `reset`=0. State returns to RUN and `mul_cnt` to 0 asynchronously. Reset during MUL_WAIT or BR_FLUSH abandons the sequence.
- Load-use: exactly 1 stall cycle, asserted in the same cycle the hazard is visible.
- Multiply: `stall_flag` is high for MUL_CYCLES-1 consecutive cycles starting in the cycle `ex_mul` first appears. This is followed by one unstalled cycle with `mul_busy`=1, giving MUL_CYCLES cycles in EX in total.
- Taken branch: 2 flush cycles on `flush_if_id` (the resolve cycle plus BR_FLUSH) and 1 cycle on `flush_id_ex`.
- Simultaneous branch and load-use: the branch wins and there is no stall, because the ID instruction is squashed.
- Branch and multiply in EX at the same time cannot occur, because EX holds a single instruction.
- `ex_rd_addr`==0 never causes a stall.

## Structure
- Shared package `ex_ctrl_pkg` holds:
  - the state enum;
  - ALUOp constants LW/SW/ADDI=2'b00, BEQ=2'b01, RTYPE=2'b10;
  - funct constants ADD=6'b000000, MUL=6'b000001, SUB=6'b000010.
- One combinational sub-module, `load_use_detect`, computes `load_use`. The FSM, `mul_cnt` and `stall_count` live in the top module.

## Test plan
- Load-use: lw with `ex_rd_addr`=5 and an ID instruction with `id_rs_addr`=5 -> `stall_flag`=1 for exactly 1 cycle and `stall_count`=1. The same case with `ex_rd_addr`=0 -> no stall.
- Multiply with MUL_CYCLES=4: `ex_mul` asserted -> `stall_flag`=1 for 3 cycles and `mul_busy`=1 for 4 cycles, then RUN. Repeat with MUL_CYCLES=2 -> 1 stall cycle.
- Taken branch (`ex_branch`=1, `ex_zero`=1) with a concurrent load-use -> `flush_if_id`=1 for 2 cycles, `flush_id_ex`=1 for 1 cycle, `stall_flag`=0. Not taken (`ex_zero`=0) -> no flush.
- Reset asserted in the 2nd cycle of MUL_WAIT -> all outputs 0 immediately. After release the block is in RUN with `stall_count`=0.
- Saturation with CNT_W=4: hold a multiply chain for more than 15 stall cycles -> `stall_count` sticks at 4'hF.
